// File: rtl/logic_accum_unit_if.sv
// Handshake bundle for logic_accum_unit.
// Producer/consumer side is master, the unit is slave.
interface logic_accum_unit_if #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16
);
  localparam int CW = $clog2(MAX_LEN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_en;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic [CW-1:0]    count;
  logic             red_and;
  logic             red_or;
  logic             trunc;

  modport master (
    output in_valid, a, b, op,
    output acc_en, last, out_ready,
    input  in_ready, out_valid, c,
    input  count, red_and, red_or, trunc
  );

  modport slave (
    input  in_valid, a, b, op,
    input  acc_en, last, out_ready,
    output in_ready, out_valid, c,
    output count, red_and, red_or, trunc
  );
endinterface

// File: rtl/logic_accum_unit.sv
// Registered bitwise logic unit with single-beat
// and burst-accumulate modes, valid/ready on both sides.
module logic_accum_unit #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16
) (
  input logic               clk,
  input logic               rst_n,
  logic_accum_unit_if.slave bus
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] LP_MAX = CW'(MAX_LEN);
  localparam logic [CW-1:0] LP_ONE = CW'(1);
  localparam bit LP_SOLO = (MAX_LEN == 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op_q;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_c;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_count;
  logic             r_red_and;
  logic             r_red_or;
  logic             r_trunc;
  logic [WIDTH-1:0] w_acc;
  logic [WIDTH-1:0] w_first;
  logic [WIDTH-1:0] w_fold;
  logic [CW-1:0]    w_cnt;
  logic             w_pub;
  logic             w_trunc;
  logic             w_fire;

  function automatic logic [WIDTH-1:0] f_op(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    r = '0;
    unique case (sel)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: r = ~(x & y);
      3'd4: r = ~(x | y);
      3'd5: r = ~(x ^ y);
      3'd6: r = x & ~y;
      3'd7: r = x;
      default: r = x;
    endcase
    return r;
  endfunction

  assign w_fire  = bus.in_valid & bus.in_ready;
  assign w_first = f_op(bus.op, bus.a, bus.b);
  assign w_fold  = f_op(r_op_q, r_acc, bus.a);

  assign bus.in_ready  = (r_state != S_HOLD);
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.c         = r_c;
  assign bus.count     = r_count;
  assign bus.red_and   = r_red_and;
  assign bus.red_or    = r_red_or;
  assign bus.trunc     = r_trunc;

  // Next state, running fold and publish decision.
  always_comb begin
    w_next  = r_state;
    w_acc   = r_acc;
    w_cnt   = r_cnt;
    w_pub   = 1'b0;
    w_trunc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          w_acc = w_first;
          w_cnt = LP_ONE;
          if (!bus.acc_en || bus.last
              || LP_SOLO) begin
            w_pub   = 1'b1;
            w_trunc = bus.acc_en & ~bus.last;
            w_next  = S_HOLD;
          end else begin
            w_next = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (w_fire) begin
          w_acc = w_fold;
          w_cnt = r_cnt + LP_ONE;
          if (bus.last) begin
            w_pub  = 1'b1;
            w_next = S_HOLD;
          end else if (w_cnt == LP_MAX) begin
            w_pub   = 1'b1;
            w_trunc = 1'b1;
            w_next  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, accumulator and published result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op_q    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_c       <= '0;
      r_count   <= '0;
      r_red_and <= 1'b0;
      r_red_or  <= 1'b0;
      r_trunc   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_acc   <= w_acc;
      r_cnt   <= w_cnt;
      if (w_fire && r_state == S_IDLE) begin
        r_op_q <= bus.op;
      end
      if (w_pub) begin
        r_c       <= w_acc;
        r_count   <= w_cnt;
        r_red_and <= &w_acc;
        r_red_or  <= |w_acc;
        r_trunc   <= w_trunc;
      end
    end
  end
endmodule

// File: tb/tb_logic_accum_unit.sv
// Bench for logic_accum_unit: spec vectors,
// corner sequences and random bursts vs a model.
module tb_logic_accum_unit;
  localparam int W  = 8;
  localparam int ML = 4;
  localparam int CW = $clog2(ML + 1);

  // per-op truth tables, bit index = {x,y}
  localparam logic [31:0] TT = {
    4'b1100, 4'b0100, 4'b1001, 4'b0001,
    4'b0111, 4'b0110, 4'b1110, 4'b1000
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_accum_unit_if #(
    .WIDTH(W), .MAX_LEN(ML)
  ) bus ();

  logic_accum_unit #(
    .WIDTH(W), .MAX_LEN(ML)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;
  logic [W-1:0] abuf [ML];

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } vec_t;
  vec_t vt [8];

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] bitop(
    input logic [2:0]   o,
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    logic [31:0] all;
    logic [3:0]  t;
    logic [W-1:0] r;
    all = TT;
    t = all[o*4 +: 4];
    for (int i = 0; i < W; i++)
      r[i] = t[{x[i], y[i]}];
    return r;
  endfunction

  function automatic logic [W-1:0] ref_fold(
    input logic [2:0]   o,
    input logic [W-1:0] bv,
    input int           n
  );
    logic [W-1:0] acc;
    acc = bitop(o, abuf[0], bv);
    for (int i = 1; i < n; i++)
      acc = bitop(o, acc, abuf[i]);
    return acc;
  endfunction

  task automatic junk();
    bus.a      = W'($urandom);
    bus.b      = W'($urandom);
    bus.op     = 3'($urandom);
    bus.acc_en = 1'($urandom);
    bus.last   = 1'($urandom);
  endtask

  task automatic beat(
    input logic [2:0]   o,
    input logic [W-1:0] av,
    input logic [W-1:0] bv,
    input logic         ae,
    input logic         ls
  );
    int k;
    bus.op = o;
    bus.a = av;
    bus.b = bv;
    bus.acc_en = ae;
    bus.last = ls;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept", 32'(k < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    junk();
  endtask

  task automatic do_txn(
    input bit           burst,
    input logic [2:0]   o,
    input logic [W-1:0] bv,
    input int           n,
    input bit           cl,
    input int           gap,
    input int           hold,
    input logic [W-1:0] ec,
    input int           ecnt,
    input bit           etr,
    input string        nm
  );
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        beat(o, abuf[0], bv, burst,
             burst ? (cl && n == 1)
                   : 1'($urandom));
      end else begin
        repeat (gap) begin
          junk();
          @(negedge clk);
        end
        beat(3'($urandom), abuf[i],
             W'($urandom), 1'($urandom),
             cl && (i == n - 1));
      end
    end
    chk({nm, ".ov"}, 32'(bus.out_valid), 1);
    chk({nm, ".c"}, 32'(bus.c), 32'(ec));
    chk({nm, ".cnt"}, 32'(bus.count),
        32'(ecnt));
    chk({nm, ".tr"}, 32'(bus.trunc),
        32'(etr));
    chk({nm, ".rand"}, 32'(bus.red_and),
        32'(&ec));
    chk({nm, ".ror"}, 32'(bus.red_or),
        32'(|ec));
    chk({nm, ".ir0"}, 32'(bus.in_ready), 0);
    bus.in_valid = 1'b1;
    repeat (hold) begin
      junk();
      @(negedge clk);
      chk({nm, ".hc"}, 32'(bus.c), 32'(ec));
      chk({nm, ".hir"}, 32'(bus.in_ready), 0);
      chk({nm, ".hov"}, 32'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, ".rov"}, 32'(bus.out_valid), 0);
    chk({nm, ".rir"}, 32'(bus.in_ready), 1);
    chk({nm, ".keep"}, 32'(bus.c), 32'(ec));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit           bu;
    bit           cl;
    logic [2:0]   o;
    logic [W-1:0] bv;
    logic [W-1:0] e;
    int           n;

    vt[0] = '{3'd0, 8'hF0, 8'h3C, 8'h30};
    vt[1] = '{3'd1, 8'hF0, 8'h3C, 8'hFC};
    vt[2] = '{3'd2, 8'hF0, 8'h3C, 8'hCC};
    vt[3] = '{3'd3, 8'hF0, 8'h3C, 8'hCF};
    vt[4] = '{3'd4, 8'hF0, 8'h3C, 8'h03};
    vt[5] = '{3'd5, 8'hF0, 8'h3C, 8'h33};
    vt[6] = '{3'd6, 8'hF0, 8'h3C, 8'hC0};
    vt[7] = '{3'd7, 8'hF0, 8'h3C, 8'hF0};

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    junk();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.ov", 32'(bus.out_valid), 0);
    chk("rst.c", 32'(bus.c), 0);
    chk("rst.cnt", 32'(bus.count), 0);
    chk("rst.ir", 32'(bus.in_ready), 1);
    chk("rst.tr", 32'(bus.trunc), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      abuf[0] = vt[i].a;
      do_txn(1'b0, vt[i].op, vt[i].b, 1, 1'b1,
             0, 0, vt[i].c, 1, 1'b0, "single");
    end

    abuf[0] = 8'hFF;
    abuf[1] = 8'h3C;
    abuf[2] = 8'hF0;
    do_txn(1'b1, 3'd0, 8'h0F, 3, 1'b1, 0, 1,
           8'h00, 3, 1'b0, "burst_and");

    abuf[0] = 8'h01;
    abuf[1] = 8'h02;
    abuf[2] = 8'h04;
    abuf[3] = 8'h08;
    do_txn(1'b1, 3'd2, 8'h02, 4, 1'b0, 0, 0,
           8'h0D, 4, 1'b1, "trunc");

    abuf[0] = 8'h5A;
    do_txn(1'b0, 3'd7, 8'h00, 1, 1'b1, 0, 5,
           8'h5A, 1, 1'b0, "backpr");

    abuf[0] = 8'h01;
    abuf[1] = 8'h10;
    abuf[2] = 8'h80;
    do_txn(1'b1, 3'd1, 8'h02, 3, 1'b1, 3, 0,
           8'h93, 3, 1'b0, "gap_op");

    beat(3'd1, 8'hAA, 8'h55, 1'b1, 1'b0);
    beat(3'd0, 8'h0F, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst.ov", 32'(bus.out_valid), 0);
    chk("mrst.c", 32'(bus.c), 0);
    chk("mrst.cnt", 32'(bus.count), 0);
    chk("mrst.ir", 32'(bus.in_ready), 1);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mrst.idle", 32'(bus.out_valid), 0);
    end
    abuf[0] = 8'hC3;
    do_txn(1'b1, 3'd6, 8'h81, 1, 1'b1, 0, 0,
           8'h42, 1, 1'b0, "post_rst");

    for (int r = 0; r < 40; r++) begin
      bu = 1'($urandom);
      o = 3'($urandom);
      bv = W'($urandom);
      if (bu) begin
        n = $urandom_range(1, ML);
        cl = (n < ML) ? 1'b1 : 1'($urandom);
      end else begin
        n = 1;
        cl = 1'b1;
      end
      for (int i = 0; i < ML; i++)
        abuf[i] = W'($urandom);
      e = ref_fold(o, bv, n);
      do_txn(bu, o, bv, n, cl,
             $urandom_range(0, 2),
             $urandom_range(0, 3),
             e, n, bu && !cl, "rnd");
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
